vector_mem_reader: RTL

- Source end of the vector stream: on a start command, reads a vector from a synchronous single-port memory.
- Emits it as a lane-parallel vector stream with data, index, keep and last, the stream that vector arithmetic blocks consume.
- Sits between on-chip vector storage (BRAM) and compute blocks.
- Handles memory read latency and downstream backpressure with an internal 3-entry buffer.

---
 rtl/vector_mem_reader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/vector_mem_reader.sv
// rtl/vector_mem_reader.sv - reads a vector from single-port memory and streams it as PAR-lane beats
module vector_mem_reader #(
   parameter int DATA_WIDTH  = 32,
   parameter int PAR         = 4,
   parameter int INDEX_WIDTH = 16,
   parameter int ADDR_WIDTH  = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [ADDR_WIDTH-1:0]     base_addr,
   input  logic [INDEX_WIDTH-1:0]    length,
   output logic                      busy,
   output logic                      done,
   output logic                      mem_ren,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   input  logic [PAR*DATA_WIDTH-1:0] mem_rdata,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [PAR*DATA_WIDTH-1:0] out_data,
   output logic [INDEX_WIDTH-1:0]    out_index,
   output logic [PAR-1:0]            out_keep,
   output logic                      out_last
);
   localparam int BW = INDEX_WIDTH + 1;
   localparam int EW = INDEX_WIDTH + $clog2(PAR) + 2;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_t;
   state_t state, state_nx;

   logic [ADDR_WIDTH-1:0]     base_q;
   logic [INDEX_WIDTH-1:0]    len_q;
   logic [BW-1:0]             beats_q, issued, rd_beat, beats_in;
   logic                      inflight;
   logic [1:0]                buf_count, wr_idx;
   logic [PAR*DATA_WIDTH-1:0] buf_data  [3];
   logic [INDEX_WIDTH-1:0]    buf_index [3];
   logic [PAR-1:0]            buf_keep  [3];
   logic [2:0]                buf_last;
   logic [2:0]                occ;
   logic                      pop, issue;
   logic [EW-1:0]             lane_base;
   logic [PAR*DATA_WIDTH-1:0] push_data;
   logic [PAR-1:0]            push_keep;
   logic                      push_last;

   assign beats_in  = ({1'b0, length} + BW'(PAR - 1)) / BW'(PAR);
   assign out_valid = (buf_count != 2'd0);
   assign pop       = out_valid & out_ready;
   // Occupancy after this cycle's pop; lets a read issue against a full buffer that is draining.
   assign occ       = {1'b0, buf_count} + {2'b0, inflight} - {2'b0, pop};
   assign issue     = (state == S_READ) && (issued < beats_q) && (occ < 3'd3);
   assign mem_ren   = issue;
   assign mem_addr  = base_q + ADDR_WIDTH'(issued);
   assign busy      = (state == S_READ) || (state == S_DRAIN);
   assign done      = (state == S_FIN);
   assign wr_idx    = buf_count - {1'b0, pop};

   assign out_data  = buf_data[0];
   assign out_index = buf_index[0];
   assign out_keep  = buf_keep[0];
   assign out_last  = buf_last[0];

   always_comb begin
      lane_base = EW'(rd_beat) * EW'(PAR);
      push_keep = '0;
      push_data = '0;
      for (int j = 0; j < PAR; j++) begin
         push_keep[j] = (lane_base + EW'(j)) < EW'(len_q);
         if (push_keep[j])
            push_data[j*DATA_WIDTH +: DATA_WIDTH] = mem_rdata[j*DATA_WIDTH +: DATA_WIDTH];
      end
      push_last = (rd_beat == beats_q - BW'(1));
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = (length == '0) ? S_FIN : S_READ;
         S_READ:  if (issue && (issued + BW'(1) == beats_q)) state_nx = S_DRAIN;
         S_DRAIN: if (pop && out_last) state_nx = S_FIN;
         S_FIN:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         base_q    <= '0;
         len_q     <= '0;
         beats_q   <= '0;
         issued    <= '0;
         rd_beat   <= '0;
         inflight  <= 1'b0;
         buf_count <= '0;
         buf_last  <= '0;
         for (int i = 0; i < 3; i++) begin
            buf_data[i]  <= '0;
            buf_index[i] <= '0;
            buf_keep[i]  <= '0;
         end
      end else begin
         state    <= state_nx;
         inflight <= issue;
         if (state == S_IDLE && start) begin
            base_q  <= base_addr;
            len_q   <= length;
            beats_q <= beats_in;
            issued  <= '0;
         end
         if (issue) begin
            issued  <= issued + BW'(1);
            rd_beat <= issued;
         end
         // Shift-register FIFO: entry 0 drives the outputs, vacated slots refill with zero.
         if (pop) begin
            buf_data[0]  <= buf_data[1];
            buf_data[1]  <= buf_data[2];
            buf_data[2]  <= '0;
            buf_index[0] <= buf_index[1];
            buf_index[1] <= buf_index[2];
            buf_index[2] <= '0;
            buf_keep[0]  <= buf_keep[1];
            buf_keep[1]  <= buf_keep[2];
            buf_keep[2]  <= '0;
            buf_last     <= {1'b0, buf_last[2:1]};
         end
         if (inflight) begin
            buf_data[wr_idx]  <= push_data;
            buf_index[wr_idx] <= INDEX_WIDTH'(lane_base);
            buf_keep[wr_idx]  <= push_keep;
            buf_last[wr_idx]  <= push_last;
         end
         buf_count <= buf_count + {1'b0, inflight} - {1'b0, pop};
      end
   end
endmodule
